perm_regfile_search: RTL and testbench
======================================

// Module: perm_regfile_search
// PURPOSE
// - Parametrised successor to the puzzle-board register file. It holds DEPTH words of WIDTH bits.
// - Contents are generated by an init engine: the even permutations of SLOTS symbols, in lexicographic order.
// - After the permutations it stores a QUESTION word. It has NRD async read ports, one write port and a masked linear-search engine.
// - Sits beside the solver datapath: the solver reads boards, overwrites them and searches for a board.
// PARAMETERS
// - SLOTS    5               number of permuted symbols, 0..SLOTS-1
// - SYM_W    3               bits per symbol field
// - WIDTH    (SLOTS+1)*SYM_W word width. Trailing field is constant SLOTS.
// - DEPTH    64              number of entries
// - ADDR_W   6               address width; DEPTH <= 2**ADDR_W
// - NRD      2               number of read ports
// - EVEN_ONLY 1              1: store even permutations only; 0: store all permutations
// - QUESTION 18'h23445       word written after the last permutation
// PORTS
// - clk          in   1            clock
// - rst_n        in   1            synchronous, active-low reset
// - we           in   1            write enable
// - wr_addr      in   ADDR_W       write address
// - wr_data      in   WIDTH        write data
// - rd_addr      in   NRD*ADDR_W   flattened read addresses; port i is slice i
// - rd_data      out  NRD*WIDTH    flattened async read data
// - ready        out  1            init done; write port and search are open
// - perm_count   out  ADDR_W+1     number of permutation entries written by init
// - search_start in   1            start request for a search
// - search_key   in   WIDTH        key to compare against
// - search_mask  in   WIDTH        compare only bits set to 1
// - search_busy  out  1            a scan is in progress
// - search_done  out  1            one-cycle pulse at the end of a scan
// - search_hit   out  1            last scan found a match
// - search_idx   out  ADDR_W       index of the first match
// BEHAVIOUR
// - Reset (rst_n=0 at an edge):
//   - all entries become 0; state goes to INIT; the candidate permutation becomes the identity; write pointer becomes 0.
//   - ready, perm_count, search_busy, search_done, search_hit and search_idx all become 0.
//   - Reset mid-scan or mid-init aborts the operation and restarts init.
// - INIT state, one candidate per edge:
//   - A candidate qualifies if EVEN_ONLY=0, or if its inversion parity is even.
//   - If it qualifies and wptr<DEPTH: write {cand, SLOTS} at wptr, then increment wptr and perm_count.
//   - If it qualifies and wptr>=DEPTH: the write is dropped and perm_count still increments.
//   - Then cand <= next_perm(cand).
//   - After the strictly descending candidate is processed: write QUESTION at wptr if wptr<DEPTH, then go to IDLE.
//   - ready rises after exactly SLOTS!+1 post-reset edges (121 for the defaults).
//   - Field 0 (symbol in slot 0) is the most significant field.
// - Writes:
//   - Accepted when ready && we && wr_addr<DEPTH, in IDLE or SEARCH.
//   - In INIT, external writes are dropped.
//   - Written data is visible on rd_data from the next cycle; there is no bypass.
// - Reads: rd_data slice i = entry[rd_addr slice i] combinationally, in every state. An address >= DEPTH reads 0.
// - Starting a search:
//   - search_start is accepted only in IDLE. It latches key and mask, sets idx=0 and search_busy=1.
//   - search_start is ignored in INIT or SEARCH.
// - SEARCH state: each cycle it tests entry[idx]: a match is ((entry ^ key) & mask) == 0.
//   - Match: search_hit=1, search_idx=idx, search_done pulses for 1 cycle, go to IDLE.
//   - No match and idx==DEPTH-1: search_hit=0, search_idx=0, search_done pulses, go to IDLE.
//   - Otherwise idx increments.
//   - A match at entry k gives search_done high k+1 edges after the accepting edge.
//   - A write to the entry under test in the same cycle: the compare uses the pre-write value.
//   - search_hit and search_idx hold until the next accepted start.
// - A mask of all zeros matches entry 0.
// STRUCTURE
// - Package perm_rf_pkg holds:
//   - state enum {INIT, IDLE, SEARCH};
//   - function factorial(n);
//   - function is_even_perm(cand), using inversion-count parity;
//   - function next_perm(cand), lexicographic successor;
//   - function is_last_perm(cand).
// - Sub-module perm_gen (registered candidate, next_perm, parity and last flag) feeds the write mux of the array.
// TESTING
// - T1 Init contents:
//   - Release reset and wait for ready (121 edges).
//   - Expect entry0=18'h014E5, entry1=18'h01715, entry59=18'h23445, entry60=QUESTION, entries61-63=0.
//   - Expect perm_count=60.
// - T2 Writes and reads:
//   - Write 18'h3FFFF to entry 7. Next cycle, port0 reads 7 -> 18'h3FFFF; port1 reads 63 -> 0.
//   - Write during INIT -> dropped.
// - T3 Search hit:
//   - key=18'h23445, mask=18'h3FFFF -> search_hit=1, search_idx=59, search_done 60 edges after accept.
//   - search_start while busy -> ignored.
// - T4 Search miss:
//   - key=18'h3FFFF, mask=18'h3FFFF on fresh contents -> search_done after 64 edges, search_hit=0, search_idx=0.
// - T5 Masked search:
//   - mask=18'h3F000 (fields 0..1), key field0=001, field1=010 -> search_idx=15.
// - T6 Mid-operation reset:
//   - Reset in cycle 30 of a scan -> busy=0, ready=0, entry7=0 before init refills it.
//   - Re-init matches T1.
//   - Run the same init with EVEN_ONLY=0, DEPTH=64: perm_count=120 and only the first 64 entries are written.

Source files
------------

// File: rtl/perm_rf_pkg.sv
// Shared types and permutation helpers for the permutation register file.
// Helpers take the live symbol count n and work on a fixed-size container.
package perm_rf_pkg;

    localparam int MAX_SLOTS = 8;
    localparam int MAX_SYM_W = 4;

    typedef logic [MAX_SYM_W-1:0]         sym_t;
    typedef sym_t [MAX_SLOTS-1:0]         perm_t;
    typedef logic [$clog2(MAX_SLOTS)-1:0] pidx_t;

    typedef enum logic [1:0] {INIT, IDLE, SEARCH} state_t;

    function automatic int factorial(input int n);
        int f;
        f = 1;
        for (int k = 2; k <= 12; k++)
            if (k <= n) f = f * k;
        return f;
    endfunction

    function automatic perm_t identity_perm(input int n);
        perm_t p;
        p = '0;
        for (int k = 0; k < MAX_SLOTS; k++)
            if (k < n) p[k] = sym_t'(k);
        return p;
    endfunction

    function automatic logic is_even_perm(input perm_t c, input int n);
        logic odd;
        odd = 1'b0;
        for (int i = 0; i < MAX_SLOTS; i++)
            for (int j = i + 1; j < MAX_SLOTS; j++)
                if (j < n && c[i] > c[j]) odd = ~odd;
        return ~odd;
    endfunction

    function automatic logic is_last_perm(input perm_t c, input int n);
        logic last;
        last = 1'b1;
        for (int k = 0; k < MAX_SLOTS - 1; k++)
            if (k + 1 < n && c[k] <= c[k+1]) last = 1'b0;
        return last;
    endfunction

    // Pivot is the rightmost ascent; swap with the rightmost larger symbol, then reverse the tail.
    function automatic perm_t next_perm(input perm_t c, input int n);
        perm_t r;
        perm_t s;
        pidx_t i;
        pidx_t j;
        logic  found;
        r     = c;
        s     = c;
        i     = '0;
        j     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_SLOTS - 1; k++)
            if (k + 1 < n && c[k] < c[k+1]) begin
                i     = pidx_t'(k);
                found = 1'b1;
            end
        if (found) begin
            for (int k = 0; k < MAX_SLOTS; k++)
                if (k > int'(i) && k < n && c[k] > c[i]) j = pidx_t'(k);
            s[i] = c[j];
            s[j] = c[i];
            r    = s;
            for (int k = 0; k < MAX_SLOTS; k++)
                if (k > int'(i) && k < n) r[k] = s[pidx_t'(n + int'(i) - k)];
        end
        return r;
    endfunction

endpackage

// File: rtl/perm_regfile_search_perm_gen.sv
// Candidate permutation register: steps through all permutations in
// lexicographic order and reports the parity and last-candidate flags.
module perm_gen
    import perm_rf_pkg::*;
#(
    parameter int SLOTS = 5,
    parameter int SYM_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   advance,
    output logic [SLOTS*SYM_W-1:0] cand_word,
    output logic                   cand_even,
    output logic                   cand_last
);

    perm_t cand;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cand <= identity_perm(SLOTS);
        else if (advance)
            cand <= next_perm(cand, SLOTS);
    end

    // NOTE: give every always_comb output a default first, otherwise partial assignment infers a latch.
    always_comb begin
        cand_word = '0;
        for (int k = 0; k < SLOTS; k++)
            cand_word[(SLOTS-1-k)*SYM_W +: SYM_W] = cand[k][SYM_W-1:0];
    end

    assign cand_even = is_even_perm(cand, SLOTS);
    assign cand_last = is_last_perm(cand, SLOTS);

endmodule

// File: rtl/perm_regfile_search.sv
// Register file pre-loaded with (even) permutations plus a question word,
// with NRD async read ports, one write port and a masked linear search.
module perm_regfile_search
    import perm_rf_pkg::*;
#(
    parameter int               SLOTS     = 5,
    parameter int               SYM_W     = 3,
    parameter int               WIDTH     = (SLOTS + 1) * SYM_W,
    parameter int               DEPTH     = 64,
    parameter int               ADDR_W    = 6,
    parameter int               NRD       = 2,
    parameter bit               EVEN_ONLY = 1'b1,
    parameter logic [WIDTH-1:0] QUESTION  = 18'h23445
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*WIDTH-1:0]  rd_data,
    output logic                  ready,
    output logic [ADDR_W:0]       perm_count,
    input  logic                  search_start,
    input  logic [WIDTH-1:0]      search_key,
    input  logic [WIDTH-1:0]      search_mask,
    output logic                  search_busy,
    output logic                  search_done,
    output logic                  search_hit,
    output logic [ADDR_W-1:0]     search_idx
);

    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [SYM_W-1:0]  TAIL     = SYM_W'(SLOTS);

    logic [WIDTH-1:0]       mem [DEPTH];
    state_t                 state;
    logic                   q_phase;
    logic [ADDR_W:0]        wptr;
    logic [ADDR_W-1:0]      idx;
    logic [WIDTH-1:0]       key_q;
    logic [WIDTH-1:0]       mask_q;
    logic [SLOTS*SYM_W-1:0] cand_word;
    logic                   cand_even;
    logic                   cand_last;
    logic                   qualify;
    logic                   wr_ok;
    logic                   match;

    perm_gen #(.SLOTS(SLOTS), .SYM_W(SYM_W)) u_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (state == INIT && !q_phase),
        .cand_word(cand_word),
        .cand_even(cand_even),
        .cand_last(cand_last)
    );

    assign qualify = !EVEN_ONLY || cand_even;
    assign wr_ok   = ready && we && ({1'b0, wr_addr} < DEPTH_V);
    assign match   = ((mem[idx] ^ key_q) & mask_q) == '0;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[p*ADDR_W +: ADDR_W];
        assign rd_data[p*WIDTH +: WIDTH] = ({1'b0, a} < DEPTH_V) ? mem[a] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the array is cleared on reset, so it must be built from flops rather than a RAM macro.
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            state       <= INIT;
            q_phase     <= 1'b0;
            wptr        <= '0;
            idx         <= '0;
            key_q       <= '0;
            mask_q      <= '0;
            ready       <= 1'b0;
            perm_count  <= '0;
            search_busy <= 1'b0;
            search_done <= 1'b0;
            search_hit  <= 1'b0;
            search_idx  <= '0;
        end else begin
            search_done <= 1'b0;
            if (wr_ok) mem[wr_addr] <= wr_data;
            case (state)
                INIT: begin
                    if (q_phase) begin
                        if (wptr < DEPTH_V) mem[wptr[ADDR_W-1:0]] <= QUESTION;
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        // Qualifying candidates past the end still count, they just are not stored.
                        if (qualify) begin
                            if (wptr < DEPTH_V) begin
                                mem[wptr[ADDR_W-1:0]] <= {cand_word, TAIL};
                                wptr                  <= wptr + CNT_ONE;
                            end
                            perm_count <= perm_count + CNT_ONE;
                        end
                        if (cand_last) q_phase <= 1'b1;
                    end
                end
                IDLE: begin
                    if (search_start) begin
                        key_q       <= search_key;
                        mask_q      <= search_mask;
                        idx         <= '0;
                        search_busy <= 1'b1;
                        search_hit  <= 1'b0;
                        search_idx  <= '0;
                        state       <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (match) begin
                        search_hit  <= 1'b1;
                        search_idx  <= idx;
                        search_done <= 1'b1;
                        search_busy <= 1'b0;
                        state       <= IDLE;
                    end else if (idx == LAST_IDX) begin
                        search_hit  <= 1'b0;
                        search_idx  <= '0;
                        search_done <= 1'b1;
                        search_busy <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_perm_regfile_search.sv
// Scoreboard bench: searches push expected results, a monitor checks them on
// search_done; init contents and reads are checked directly.
module tb_perm_regfile_search;

    localparam int AW  = 6;
    localparam int W   = 18;
    localparam int NRD = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              we;
    logic [AW-1:0]     wr_addr;
    logic [W-1:0]      wr_data;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*W-1:0]  rd_data;
    logic              ready;
    logic [AW:0]       perm_count;
    logic              search_start;
    logic [W-1:0]      search_key;
    logic [W-1:0]      search_mask;
    logic              search_busy;
    logic              search_done;
    logic              search_hit;
    logic [AW-1:0]     search_idx;

    logic [NRD*AW-1:0] rd_addr_all;
    logic [NRD*W-1:0]  rd_data_all;
    logic              ready_all;
    logic [AW:0]       perm_count_all;
    logic              busy_all;
    logic              done_all;
    logic              hit_all;
    logic [AW-1:0]     idx_all;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_rdy;

    typedef struct {
        string         name;
        logic          hit;
        logic [AW-1:0] idx;
        int            done_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    perm_regfile_search dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .ready(ready), .perm_count(perm_count),
        .search_start(search_start), .search_key(search_key), .search_mask(search_mask),
        .search_busy(search_busy), .search_done(search_done), .search_hit(search_hit),
        .search_idx(search_idx)
    );

    perm_regfile_search #(.EVEN_ONLY(1'b0)) dut_all (
        .clk(clk), .rst_n(rst_n), .we(1'b0), .wr_addr(6'd0), .wr_data(18'h0),
        .rd_addr(rd_addr_all), .rd_data(rd_data_all), .ready(ready_all), .perm_count(perm_count_all),
        .search_start(1'b0), .search_key(18'h0), .search_mask(18'h0),
        .search_busy(busy_all), .search_done(done_all), .search_hit(hit_all),
        .search_idx(idx_all)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && search_done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected search_done at cycle %0d", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, " hit"}, search_hit, mon_e.hit);
                check({mon_e.name, " idx"}, search_idx, mon_e.idx);
                check({mon_e.name, " done cycle"}, cyc, mon_e.done_cyc);
                check({mon_e.name, " busy at done"}, search_busy, 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic read_chk(input string name, input int port, input logic [AW-1:0] a,
                            input logic [W-1:0] exp);
        rd_addr[port*AW +: AW] = a;
        #1;
        check(name, rd_data[port*W +: W], exp);
    endtask

    task automatic read_all_chk(input string name, input int port, input logic [AW-1:0] a,
                                input logic [W-1:0] exp);
        rd_addr_all[port*AW +: AW] = a;
        #1;
        check(name, rd_data_all[port*W +: W], exp);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready && n < 200);
    endtask

    task automatic check_init(input string tag);
        check({tag, " ready"}, ready, 1);
        check({tag, " perm_count"}, perm_count, 60);
        read_chk({tag, " entry0"}, 0, 6'd0, 18'h014E5);
        read_chk({tag, " entry1"}, 1, 6'd1, 18'h01715);
        read_chk({tag, " entry59"}, 0, 6'd59, 18'h23445);
        read_chk({tag, " entry60"}, 1, 6'd60, 18'h23445);
        read_chk({tag, " entry61"}, 0, 6'd61, 18'h0);
        read_chk({tag, " entry62"}, 1, 6'd62, 18'h0);
        read_chk({tag, " entry63"}, 0, 6'd63, 18'h0);
    endtask

    task automatic search(input string name, input logic [W-1:0] key, input logic [W-1:0] mask,
                          input logic exp_hit, input logic [AW-1:0] exp_idx, input int lat,
                          input bit poke);
        int n;
        search_start = 1'b1;
        search_key   = key;
        search_mask  = mask;
        sb_q.push_back('{name, exp_hit, exp_idx, cyc + 1 + lat});
        tick();
        search_start = 1'b0;
        if (poke) begin
            repeat (10) tick();
            check({name, " busy mid-scan"}, search_busy, 1);
            search_start = 1'b1;
            search_key   = '0;
            search_mask  = '0;
            tick();
            search_start = 1'b0;
        end
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no search_done within 100 cycles", name);
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        we           = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        rd_addr      = '0;
        rd_addr_all  = '0;
        search_start = 1'b0;
        search_key   = '0;
        search_mask  = '0;
        repeat (2) tick();

        check("rst ready", ready, 0);
        check("rst perm_count", perm_count, 0);
        check("rst busy", search_busy, 0);
        check("rst done", search_done, 0);
        check("rst hit", search_hit, 0);
        check("rst idx", search_idx, 0);
        read_chk("rst entry60", 0, 6'd60, 18'h0);

        // T1: init, with an external write held on entry 61 throughout
        we      = 1'b1;
        wr_addr = 6'd61;
        wr_data = 18'h3FFFF;
        rst_n   = 1'b1;
        wait_ready(n_rdy);
        we = 1'b0;
        check("ready latency", n_rdy, 121);
        check_init("init");

        check("all ready", ready_all, 1);
        check("all perm_count", perm_count_all, 120);
        read_all_chk("all entry0", 0, 6'd0, 18'h014E5);
        read_all_chk("all entry1", 1, 6'd1, 18'h0151D);
        read_all_chk("all entry63", 0, 6'd63, 18'h13305);
        check("all idle busy", busy_all, 0);
        check("all idle done", done_all, 0);
        check("all idle hit", hit_all, 0);
        check("all idle idx", idx_all, 0);

        // T4: miss on fresh contents
        search("miss", 18'h3FFFF, 18'h3FFFF, 1'b0, 6'd0, 64, 1'b0);

        // T2: write then read back on both ports
        wr_addr = 6'd7;
        wr_data = 18'h3FFFF;
        we      = 1'b1;
        tick();
        we = 1'b0;
        read_chk("wr entry7 port0", 0, 6'd7, 18'h3FFFF);
        read_chk("wr entry63 port1", 1, 6'd63, 18'h0);

        // T3: full-key hit with an ignored start mid-scan
        search("hit question", 18'h23445, 18'h3FFFF, 1'b1, 6'd59, 60, 1'b1);
        search("zero mask", 18'h12345, 18'h0, 1'b1, 6'd0, 1, 1'b0);

        // T5: fields 0..1 equal to 1,2
        search("masked", 18'h0A000, 18'h3F000, 1'b1, 6'd15, 16, 1'b0);
        repeat (3) tick();
        check("hold hit", search_hit, 1);
        check("hold idx", search_idx, 15);

        // T6: reset in cycle 30 of a scan
        search_start = 1'b1;
        search_key   = 18'h3FFFE;
        search_mask  = 18'h3FFFF;
        tick();
        search_start = 1'b0;
        repeat (28) tick();
        check("pre-abort busy", search_busy, 1);
        rst_n = 1'b0;
        tick();
        check("abort busy", search_busy, 0);
        check("abort ready", ready, 0);
        check("abort hit", search_hit, 0);
        check("abort perm_count", perm_count, 0);
        read_chk("abort entry7", 0, 6'd7, 18'h0);
        rst_n = 1'b1;
        wait_ready(n_rdy);
        check("reinit latency", n_rdy, 121);
        check_init("reinit");
        check("reinit all perm_count", perm_count_all, 120);

        check("scoreboard drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
